// File: rtl/spell_mem_banked.sv
// Banked code/data memory with a fixed-latency select-held transaction handshake.
// Latency: data_ready rises LATENCY cycles after the edge that accepts select.
// Backpressure: none; the requester holds select until data_ready and must drop it to finish.
//
// Ports:
//   clock, reset              - system clock, synchronous active-high reset
//   select                    - transaction request; held high for the whole transaction
//   addr, data_in             - word address and write data, latched at transaction start
//   memory_type               - bank select: MEM_TYPE_DATA (0) or MEM_TYPE_CODE (1); other values flag error
//   write                     - 1 = write, 0 = read
//   data_out                  - last read data, held until the next completed read
//   data_ready, error         - completion and invalid-bank flags, held while select stays high
//   busy                      - power-on bank clear in progress
//
// Optional build macro SPELL_MEM_CLEAR_EN: after reset both banks are zeroed, one word
// per cycle, while busy is high. Without it the banks are left untouched by reset.
module spell_mem_banked #(
    parameter int DATA_W  = 8,
    parameter int ADDR_W  = 8,
    parameter int LATENCY = 4
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              select,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] data_in,
    input  logic [1:0]        memory_type,
    input  logic              write,
    output logic [DATA_W-1:0] data_out,
    output logic              data_ready,
    output logic              error,
    output logic              busy
);

    localparam logic [1:0] MEM_TYPE_DATA = 2'd0;
    localparam logic [1:0] MEM_TYPE_CODE = 2'd1;
    localparam int         DEPTH         = 1 << ADDR_W;

`ifdef SPELL_MEM_CLEAR_EN
    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_DONE, S_CLEAR} state_t;
    localparam state_t RESET_STATE = S_CLEAR;
`else
    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_DONE} state_t;
    localparam state_t RESET_STATE = S_IDLE;
`endif

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q;
    logic [1:0]        type_q;
    logic              write_q;
    logic [3:0]        count_q;
    logic              exec;
    logic              type_ok;
    logic              bank_we;

    logic [DATA_W-1:0] code_mem [DEPTH];
    logic [DATA_W-1:0] data_mem [DEPTH];

`ifdef SPELL_MEM_CLEAR_EN
    logic [ADDR_W-1:0] clr_ptr;
    logic              clr_we;
`endif

    assign type_ok = (type_q == MEM_TYPE_DATA) || (type_q == MEM_TYPE_CODE);
    // Reset in the same cycle as the access edge must suppress the write.
    assign bank_we = exec && write_q && type_ok && !reset;

    always_ff @(posedge clock) begin
        if (reset) state_q <= RESET_STATE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        exec    = 1'b0;
        case (state_q)
            S_IDLE: if (select) state_d = S_WAIT;
            S_WAIT: begin
                if (!select) begin
                    state_d = S_IDLE;
                end else if (count_q == 4'd0) begin
                    state_d = S_DONE;
                    exec    = 1'b1;
                end
            end
            S_DONE: if (!select) state_d = S_IDLE;
`ifdef SPELL_MEM_CLEAR_EN
            // select is ignored here; a held select is picked up in the first IDLE cycle.
            S_CLEAR: if (&clr_ptr) state_d = S_IDLE;
`endif
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            addr_q     <= '0;
            wdata_q    <= '0;
            type_q     <= '0;
            write_q    <= 1'b0;
            count_q    <= 4'd0;
            data_out   <= '0;
            data_ready <= 1'b0;
            error      <= 1'b0;
        end else begin
            if (state_q == S_IDLE && select) begin
                addr_q  <= addr;
                wdata_q <= data_in;
                type_q  <= memory_type;
                write_q <= write;
                count_q <= 4'(LATENCY - 1);
            end
            if (state_q == S_WAIT && count_q != 4'd0) begin
                count_q <= count_q - 4'd1;
            end
            if (exec) begin
                data_ready <= 1'b1;
                error      <= !type_ok;
                if (!write_q && type_ok) begin
                    data_out <= (type_q == MEM_TYPE_CODE) ? code_mem[addr_q] : data_mem[addr_q];
                end
            end
            if (state_q == S_DONE && !select) begin
                data_ready <= 1'b0;
                error      <= 1'b0;
            end
        end
    end

`ifdef SPELL_MEM_CLEAR_EN
    assign clr_we = (state_q == S_CLEAR) && !reset;
    assign busy   = (state_q == S_CLEAR);

    always_ff @(posedge clock) begin
        if (reset)       clr_ptr <= '0;
        else if (clr_we) clr_ptr <= clr_ptr + 1'b1;
    end

    always_ff @(posedge clock) begin
        if (clr_we) begin
            code_mem[clr_ptr] <= '0;
            data_mem[clr_ptr] <= '0;
        end else if (bank_we) begin
            if (type_q == MEM_TYPE_CODE) code_mem[addr_q] <= wdata_q;
            else                         data_mem[addr_q] <= wdata_q;
        end
    end
`else
    assign busy = 1'b0;

    always_ff @(posedge clock) begin
        if (bank_we) begin
            if (type_q == MEM_TYPE_CODE) code_mem[addr_q] <= wdata_q;
            else                         data_mem[addr_q] <= wdata_q;
        end
    end
`endif

endmodule

// File: tb/tb_spell_mem_banked.sv
module tb_spell_mem_banked;

    localparam int DATA_W = 8;
    localparam int ADDR_W = 8;
    localparam int LAT    = 4;
    localparam int DEPTH  = 1 << ADDR_W;
    localparam logic [1:0] MT_DATA = 2'd0;
    localparam logic [1:0] MT_CODE = 2'd1;
    localparam logic [1:0] MT_BAD  = 2'd2;

    logic              clock = 1'b0;
    logic              reset;
    logic              select;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data_in;
    logic [1:0]        memory_type;
    logic              write;
    logic [DATA_W-1:0] data_out;
    logic              data_ready;
    logic              error;
    logic              busy;

    spell_mem_banked #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .LATENCY(LAT)) dut (
        .clock(clock), .reset(reset), .select(select), .addr(addr),
        .data_in(data_in), .memory_type(memory_type), .write(write),
        .data_out(data_out), .data_ready(data_ready), .error(error), .busy(busy)
    );

    always #5 clock = ~clock;

    int checks = 0;
    int errors = 0;

    // Reference model: bank contents and the held data_out value.
    logic [DATA_W-1:0] m_code [DEPTH];
    logic [DATA_W-1:0] m_data [DEPTH];
    logic [DATA_W-1:0] m_dout;

    typedef struct packed {
        logic              err;
        logic [DATA_W-1:0] dout;
    } exp_t;
    exp_t exp_q[$];

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // Full transaction: push expectation, drive, wait for data_ready, pop and compare.
    task automatic txn(input logic [1:0] mt, input logic [ADDR_W-1:0] a,
                       input logic [DATA_W-1:0] d, input logic wr,
                       input bit scramble, input int hold);
        exp_t e;
        exp_t exp;
        int   n;
        e.err = !(mt == MT_DATA || mt == MT_CODE);
        if (!e.err && wr) begin
            if (mt == MT_CODE) m_code[a] = d;
            else               m_data[a] = d;
        end else if (!e.err && !wr) begin
            m_dout = (mt == MT_CODE) ? m_code[a] : m_data[a];
        end
        e.dout = m_dout;
        exp_q.push_back(e);

        select = 1'b1; addr = a; data_in = d; memory_type = mt; write = wr;
        tick();  // start edge
        if (scramble) begin
            addr = ~a; data_in = ~d; memory_type = mt ^ 2'b01; write = ~wr;
        end
        n = 0;
        while (!data_ready && n < 20) begin
            tick();
            n++;
        end
        exp = exp_q.pop_front();
        checks++;
        if (n !== LAT) begin
            errors++;
            $display("FAIL latency a=%h got %0d cycles want %0d", a, n, LAT);
        end
        checks++;
        if (error !== exp.err) begin
            errors++;
            $display("FAIL error_flag a=%h got %b want %b", a, error, exp.err);
        end
        checks++;
        if (data_out !== exp.dout) begin
            errors++;
            $display("FAIL data_out a=%h got %h want %h", a, data_out, exp.dout);
        end
        for (int i = 0; i < hold; i++) begin
            tick();
            checks++;
            if (data_ready !== 1'b1 || error !== exp.err) begin
                errors++;
                $display("FAIL done_hold got rdy=%b err=%b want rdy=1 err=%b", data_ready, error, exp.err);
            end
        end
        select = 1'b0;
        tick();
        checks++;
        if (data_ready !== 1'b0 || error !== 1'b0 || data_out !== exp.dout) begin
            errors++;
            $display("FAIL release got rdy=%b err=%b dout=%h want rdy=0 err=0 dout=%h",
                     data_ready, error, data_out, exp.dout);
        end
    endtask

    task automatic test_reset();
        int n;
        reset = 1'b1; select = 1'b0;
        tick();
        tick();
        checks++;
        if (data_ready !== 1'b0 || error !== 1'b0 || data_out !== '0) begin
            errors++;
            $display("FAIL reset_outputs got rdy=%b err=%b dout=%h want 0 0 00", data_ready, error, data_out);
        end
        reset = 1'b0;
        m_dout = '0;
`ifdef SPELL_MEM_CLEAR_EN
        n = 0;
        while (busy && n < DEPTH + 10) begin
            n++;
            tick();
        end
        checks++;
        if (n !== DEPTH) begin
            errors++;
            $display("FAIL clear_busy got %0d cycles want %0d", n, DEPTH);
        end
        for (int i = 0; i < DEPTH; i++) begin
            m_code[i] = '0;
            m_data[i] = '0;
        end
`else
        n = 0;
        tick();
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL busy_idle got %b want 0", busy);
        end
`endif
    endtask

    task automatic test_basic();
        txn(MT_DATA, 8'h12, 8'hA5, 1'b1, 1'b0, 0);
        txn(MT_DATA, 8'h12, 8'h00, 1'b0, 1'b0, 0);
    endtask

    task automatic test_banks();
        txn(MT_CODE, 8'h12, 8'h3C, 1'b1, 1'b0, 0);
        txn(MT_DATA, 8'h12, 8'h5A, 1'b1, 1'b0, 0);
        txn(MT_CODE, 8'h12, 8'h00, 1'b0, 1'b0, 0);
        txn(MT_DATA, 8'h12, 8'h00, 1'b0, 1'b0, 2);
        txn(MT_CODE, 8'hFF, 8'hC3, 1'b1, 1'b0, 0);
        txn(MT_DATA, 8'h00, 8'h81, 1'b1, 1'b0, 0);
        txn(MT_CODE, 8'hFF, 8'h00, 1'b0, 1'b0, 0);
        txn(MT_DATA, 8'h00, 8'h00, 1'b0, 1'b0, 0);
    endtask

    task automatic test_latch();
        txn(MT_DATA, 8'h21, 8'h11, 1'b1, 1'b0, 0);
        txn(MT_CODE, 8'hDE, 8'h22, 1'b1, 1'b0, 0);
        txn(MT_DATA, 8'h21, 8'h00, 1'b0, 1'b1, 0);  // read data 0x21; bus changes afterwards
        txn(MT_CODE, 8'h30, 8'h44, 1'b1, 1'b1, 0);  // write must land in code 0x30
        txn(MT_CODE, 8'h30, 8'h00, 1'b0, 1'b0, 0);
    endtask

    task automatic test_abort();
        logic [DATA_W-1:0] held;
        txn(MT_DATA, 8'h40, 8'h11, 1'b1, 1'b0, 0);
        held = m_dout;
        select = 1'b1; addr = 8'h40; data_in = 8'h77; memory_type = MT_DATA; write = 1'b1;
        tick();
        tick();
        tick();
        select = 1'b0;
        for (int i = 0; i < 6; i++) begin
            tick();
            checks++;
            if (data_ready !== 1'b0 || data_out !== held) begin
                errors++;
                $display("FAIL abort got rdy=%b dout=%h want rdy=0 dout=%h", data_ready, data_out, held);
            end
        end
        txn(MT_DATA, 8'h40, 8'h00, 1'b0, 1'b0, 0);
    endtask

    task automatic test_bad_type();
        txn(MT_BAD, 8'h12, 8'hFF, 1'b1, 1'b0, 1);
        txn(2'd3,   8'h12, 8'hFF, 1'b0, 1'b0, 0);
        txn(MT_DATA, 8'h12, 8'h00, 1'b0, 1'b0, 0);
        txn(MT_CODE, 8'h12, 8'h00, 1'b0, 1'b0, 0);
    endtask

    task automatic test_reset_mid();
        txn(MT_DATA, 8'h55, 8'h99, 1'b1, 1'b0, 0);
        select = 1'b1; addr = 8'h55; data_in = 8'h00; memory_type = MT_DATA; write = 1'b1;
        tick();
        tick();
        tick();
        select = 1'b0;
        test_reset();
        txn(MT_DATA, 8'h55, 8'h00, 1'b0, 1'b0, 0);
    endtask

`ifdef SPELL_MEM_CLEAR_EN
    task automatic test_clear_restart();
        int n;
        txn(MT_CODE, 8'h07, 8'hAB, 1'b1, 1'b0, 0);
        txn(MT_DATA, 8'h0F, 8'hCD, 1'b1, 1'b0, 0);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        for (int i = 0; i < 7; i++) tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        n = 0;
        while (busy && n < DEPTH + 10) begin
            n++;
            tick();
        end
        checks++;
        if (n !== DEPTH) begin
            errors++;
            $display("FAIL clear_restart got %0d cycles want %0d", n, DEPTH);
        end
        m_dout = '0;
        for (int i = 0; i < DEPTH; i++) begin
            m_code[i] = '0;
            m_data[i] = '0;
        end
        txn(MT_CODE, 8'h07, 8'h00, 1'b0, 1'b0, 0);
        txn(MT_DATA, 8'h0F, 8'h00, 1'b0, 1'b0, 0);
    endtask
`endif

    initial begin
        reset = 1'b1; select = 1'b0; addr = '0; data_in = '0; memory_type = MT_DATA; write = 1'b0;
        m_dout = '0;
        test_reset();
        test_basic();
        test_banks();
        test_latch();
        test_abort();
        test_bad_type();
        test_reset_mid();
`ifdef SPELL_MEM_CLEAR_EN
        test_clear_restart();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
